// File: rtl/spi_reg_bridge_if.sv
// Bus bundle between the SPI slave shifter, the frame bridge and the register file.
// slave: bridge side; master: shifter/register-file side.
interface spi_reg_bridge_if #(
   parameter int PARA_DATA_WIDTH = 8,
   parameter int PARA_ADDR_WIDTH = 8
);
   logic                       spi_cs_n;
   logic [PARA_DATA_WIDTH-1:0] spi_rxdata;
   logic                       spi_rxdata_valid;
   logic [PARA_DATA_WIDTH-1:0] spi_txdata;
   logic [PARA_ADDR_WIDTH-1:0] reg_addr;
   logic [PARA_DATA_WIDTH-1:0] reg_wdata;
   logic                       reg_wr_en;
   logic                       reg_rd_en;
   logic [PARA_DATA_WIDTH-1:0] reg_rdata;
   logic                       cmd_err;

   modport slave (
      input  spi_cs_n, spi_rxdata, spi_rxdata_valid, reg_rdata,
      output spi_txdata, reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
      output cmd_err
   );

   modport master (
      output spi_cs_n, spi_rxdata, spi_rxdata_valid, reg_rdata,
      input  spi_txdata, reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
      input  cmd_err
   );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI frame decoder (CMD/ADDR/DATA) driving a register-file bus, spi_sck domain.
// Ports: spi_sck, spi_slv_rst_spi_sck (async, active-high), bus (slave modport).
module spi_reg_bridge #(
   parameter int PARA_DATA_WIDTH = 8,
   parameter int PARA_ADDR_WIDTH = 8
) (
   input logic             spi_sck,
   input logic             spi_slv_rst_spi_sck,
   spi_reg_bridge_if.slave bus
);
   localparam logic [2:0] ST_CMD     = 3'd0;
   localparam logic [2:0] ST_ADDR_WR = 3'd1;
   localparam logic [2:0] ST_ADDR_RD = 3'd2;
   localparam logic [2:0] ST_WR_DATA = 3'd3;
   localparam logic [2:0] ST_RD_DATA = 3'd4;
   localparam logic [2:0] ST_IGNORE  = 3'd5;

   localparam logic [PARA_DATA_WIDTH-1:0] CMD_WR = PARA_DATA_WIDTH'(8'h02);
   localparam logic [PARA_DATA_WIDTH-1:0] CMD_RD = PARA_DATA_WIDTH'(8'h03);

   logic                       cs_n;
   logic                       rx_valid;
   logic [PARA_DATA_WIDTH-1:0] rxdata;
   logic [PARA_DATA_WIDTH-1:0] rdata;

   assign cs_n     = bus.spi_cs_n;
   assign rx_valid = bus.spi_rxdata_valid;
   assign rxdata   = bus.spi_rxdata;
   assign rdata    = bus.reg_rdata;

   logic [2:0]                 state_q, state_d;
   logic [PARA_ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic                       wr_en_q, wr_en_d;
   logic                       rd_en_q, rd_en_d;
   logic [PARA_DATA_WIDTH-1:0] txdata_q, txdata_d;
   logic [PARA_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                       cmd_err_q, cmd_err_d;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      txdata_d  = txdata_q;
      wdata_d   = wdata_q;
      cmd_err_d = cmd_err_q;
      // Write strobe lasts one cycle; the pointer advances as it retires.
      if (wr_en_q)
         ptr_d = ptr_q + 1'b1;
      // Read data is captured as the read strobe retires, well ahead of the
      // shifter's load edge for the next byte.
      if (rd_en_q)
         txdata_d = rdata;
      if (rx_valid) begin
         unique case (state_q)
            ST_CMD: begin
               if (rxdata == CMD_WR)
                  state_d = ST_ADDR_WR;
               else if (rxdata == CMD_RD)
                  state_d = ST_ADDR_RD;
               else begin
                  state_d   = ST_IGNORE;
                  cmd_err_d = 1'b1;
               end
            end
            ST_ADDR_WR: begin
               ptr_d   = rxdata[PARA_ADDR_WIDTH-1:0];
               state_d = ST_WR_DATA;
            end
            ST_ADDR_RD: begin
               ptr_d   = rxdata[PARA_ADDR_WIDTH-1:0];
               rd_en_d = 1'b1;
               state_d = ST_RD_DATA;
            end
            ST_WR_DATA: begin
               wdata_d = rxdata;
               wr_en_d = 1'b1;
            end
            ST_RD_DATA: begin
               // Prefetch the next location; one extra read past the
               // last byte the master clocks out is inherent.
               ptr_d   = ptr_q + 1'b1;
               rd_en_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Frame state: cleared asynchronously by reset or by chip-select release.
   always_ff @(posedge spi_sck or posedge spi_slv_rst_spi_sck or posedge cs_n) begin
      if (spi_slv_rst_spi_sck) begin
         state_q  <= ST_CMD;
         ptr_q    <= '0;
         wr_en_q  <= 1'b0;
         rd_en_q  <= 1'b0;
         txdata_q <= '0;
      end else if (cs_n) begin
         state_q  <= ST_CMD;
         ptr_q    <= '0;
         wr_en_q  <= 1'b0;
         rd_en_q  <= 1'b0;
         txdata_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         wr_en_q  <= wr_en_d;
         rd_en_q  <= rd_en_d;
         txdata_q <= txdata_d;
      end
   end

   // Sticky error and write data survive chip-select release.
   always_ff @(posedge spi_sck or posedge spi_slv_rst_spi_sck) begin
      if (spi_slv_rst_spi_sck) begin
         cmd_err_q <= 1'b0;
         wdata_q   <= '0;
      end else if (!cs_n) begin
         cmd_err_q <= cmd_err_d;
         wdata_q   <= wdata_d;
      end
   end

   assign bus.spi_txdata = txdata_q;
   assign bus.reg_addr   = ptr_q;
   assign bus.reg_wdata  = wdata_q;
   assign bus.reg_wr_en  = wr_en_q;
   assign bus.reg_rd_en  = rd_en_q;
   assign bus.cmd_err    = cmd_err_q;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Frame-level bench for spi_reg_bridge: directed table, corner sequences,
// and random frames checked against a byte-level reference model.
module tb_spi_reg_bridge;
   typedef logic [0:7][7:0] bytes8_t;
   typedef logic [0:3][7:0] bytes4_t;

   typedef struct {
      string   nm;
      bytes8_t b;
      int      n;
      int      ab_slot;
      int      ab_bits;
      int      nw;
      bytes4_t wa;
      bytes4_t wd;
      int      nr;
      bytes4_t ra;
      bytes8_t miso;
      logic    err;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   spi_reg_bridge_if #(.PARA_DATA_WIDTH(8), .PARA_ADDR_WIDTH(8)) bus ();

   spi_reg_bridge #(
      .PARA_DATA_WIDTH(8),
      .PARA_ADDR_WIDTH(8)
   ) dut (
      .spi_sck            (clk),
      .spi_slv_rst_spi_sck(rst),
      .bus                (bus.slave)
   );

   logic [7:0]  mem  [256];
   logic [7:0]  mmem [256];
   logic        err_m;
   logic [15:0] wlog [$];
   logic [7:0]  rlog [$];
   logic [15:0] exp_w [$];
   logic [7:0]  exp_r [$];
   logic [7:0]  exp_m [8];
   logic [7:0]  miso  [8];
   int          ws, rs;
   int          n_cmp = 0;
   int          n_bad = 0;
   vec_t        tv [7];

   assign bus.reg_rdata = mem[bus.reg_addr];

   always @(negedge clk) begin
      if (bus.reg_wr_en)
         wlog.push_back({bus.reg_addr, bus.reg_wdata});
      if (bus.reg_rd_en)
         rlog.push_back(bus.reg_addr);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic slot(input bit v, input logic [7:0] d);
      for (int e = 0; e < 8; e++) begin
         bus.spi_rxdata_valid = v && (e == 0);
         bus.spi_rxdata       = d;
         @(posedge clk);
         @(negedge clk);
      end
      bus.spi_rxdata_valid = 1'b0;
   endtask

   task automatic apply_writes();
      for (int i = ws; i < wlog.size(); i++)
         mem[wlog[i][15:8]] = wlog[i][7:0];
   endtask

   task automatic run_frame(input bytes8_t fb, input int n,
                            input int ab_slot, input int ab_bits);
      int nsl;
      bit stop;
      ws   = wlog.size();
      rs   = rlog.size();
      nsl  = (ab_slot >= 0) ? ab_slot + 1 : n;
      stop = 1'b0;
      @(negedge clk);
      bus.spi_cs_n = 1'b0;
      for (int k = 0; k < nsl && !stop; k++) begin
         miso[k] = bus.spi_txdata;
         for (int e = 0; e < 8; e++) begin
            bus.spi_rxdata_valid = (e == 0) && (k > 0);
            bus.spi_rxdata       = (k > 0) ? fb[k-1] : 8'h00;
            @(posedge clk);
            @(negedge clk);
            bus.spi_rxdata_valid = 1'b0;
            if (k == ab_slot && e + 1 == ab_bits) begin
               stop = 1'b1;
               break;
            end
         end
      end
      bus.spi_cs_n = 1'b1;
      repeat (2) @(negedge clk);
      apply_writes();
   endtask

   // Byte-level model: P = number of bytes whose valid pulse was followed
   // by an sck edge.
   task automatic model_frame(input bytes8_t fb, input int nsl, input int p);
      logic [7:0] a;
      exp_w.delete();
      exp_r.delete();
      for (int k = 0; k < 8; k++)
         exp_m[k] = 8'h00;
      if (p >= 1) begin
         if (fb[0] == 8'h02) begin
            for (int i = 2; i < p; i++) begin
               a = fb[1] + 8'(i - 2);
               exp_w.push_back({a, fb[i]});
               mmem[a] = fb[i];
            end
         end else if (fb[0] == 8'h03) begin
            for (int j = 0; j <= p - 2; j++)
               exp_r.push_back(fb[1] + 8'(j));
            for (int k = 3; k < nsl; k++)
               exp_m[k] = mmem[8'(fb[1] + 8'(k - 3))];
         end else begin
            err_m = 1'b1;
         end
      end
   endtask

   task automatic cmp_frame(input string nm, input int nsl, input logic e_err);
      chk({nm, " wr count"}, wlog.size() - ws, exp_w.size());
      for (int i = 0; i < exp_w.size() && ws + i < wlog.size(); i++)
         chk({nm, " wr addr/data"}, wlog[ws+i], exp_w[i]);
      chk({nm, " rd count"}, rlog.size() - rs, exp_r.size());
      for (int i = 0; i < exp_r.size() && rs + i < rlog.size(); i++)
         chk({nm, " rd addr"}, rlog[rs+i], exp_r[i]);
      for (int k = 0; k < nsl; k++)
         chk({nm, " miso"}, miso[k], exp_m[k]);
      chk({nm, " cmd_err"}, bus.cmd_err, e_err);
   endtask

   initial begin
      bus.spi_cs_n         = 1'b1;
      bus.spi_rxdata       = 8'h00;
      bus.spi_rxdata_valid = 1'b0;
      err_m                = 1'b0;
      for (int i = 0; i < 256; i++) begin
         mem[i]  = 8'(i) ^ 8'h5C;
         mmem[i] = 8'(i) ^ 8'h5C;
      end
      mem[8'h20] = 8'h5A; mem[8'h21] = 8'hA5; mem[8'h22] = 8'h3C;
      mem[8'h40] = 8'h77; mem[8'h41] = 8'h88;
      for (int i = 0; i < 256; i++)
         mmem[i] = mem[i];

      tv[0] = '{nm:"write burst",
                b:{8'h02,8'h10,8'hAA,8'hBB,8'hCC,8'h00,8'h00,8'h00},
                n:6, ab_slot:-1, ab_bits:0,
                nw:3, wa:{8'h10,8'h11,8'h12,8'h00},
                wd:{8'hAA,8'hBB,8'hCC,8'h00},
                nr:0, ra:'0, miso:'0, err:1'b0};
      tv[1] = '{nm:"read burst",
                b:{8'h03,8'h20,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                n:6, ab_slot:-1, ab_bits:0,
                nw:0, wa:'0, wd:'0,
                nr:4, ra:{8'h20,8'h21,8'h22,8'h23},
                miso:{8'h00,8'h00,8'h00,8'h5A,8'hA5,8'h3C,8'h00,8'h00},
                err:1'b0};
      tv[2] = '{nm:"wrap",
                b:{8'h02,8'hFF,8'h11,8'h22,8'h00,8'h00,8'h00,8'h00},
                n:5, ab_slot:-1, ab_bits:0,
                nw:2, wa:{8'hFF,8'h00,8'h00,8'h00},
                wd:{8'h11,8'h22,8'h00,8'h00},
                nr:0, ra:'0, miso:'0, err:1'b0};
      tv[3] = '{nm:"illegal cmd",
                b:{8'h07,8'h10,8'hAA,8'hBB,8'h00,8'h00,8'h00,8'h00},
                n:4, ab_slot:-1, ab_bits:0,
                nw:0, wa:'0, wd:'0, nr:0, ra:'0, miso:'0, err:1'b1};
      tv[4] = '{nm:"read after illegal",
                b:{8'h03,8'h20,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                n:4, ab_slot:-1, ab_bits:0,
                nw:0, wa:'0, wd:'0,
                nr:2, ra:{8'h20,8'h21,8'h00,8'h00},
                miso:{8'h00,8'h00,8'h00,8'h5A,8'h00,8'h00,8'h00,8'h00},
                err:1'b1};
      tv[5] = '{nm:"abort mid byte",
                b:{8'h02,8'h30,8'hD0,8'hD1,8'hD2,8'h00,8'h00,8'h00},
                n:5, ab_slot:4, ab_bits:4,
                nw:2, wa:{8'h30,8'h31,8'h00,8'h00},
                wd:{8'hD0,8'hD1,8'h00,8'h00},
                nr:0, ra:'0, miso:'0, err:1'b1};
      tv[6] = '{nm:"read after abort",
                b:{8'h03,8'h40,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                n:5, ab_slot:-1, ab_bits:0,
                nw:0, wa:'0, wd:'0,
                nr:3, ra:{8'h40,8'h41,8'h42,8'h00},
                miso:{8'h00,8'h00,8'h00,8'h77,8'h88,8'h00,8'h00,8'h00},
                err:1'b1};

      // Reset state.
      repeat (2) @(negedge clk);
      chk("reset txdata", bus.spi_txdata, 8'h00);
      chk("reset addr", bus.reg_addr, 8'h00);
      chk("reset wdata", bus.reg_wdata, 8'h00);
      chk("reset strobes", {bus.reg_wr_en, bus.reg_rd_en}, 2'b00);
      chk("reset cmd_err", bus.cmd_err, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Directed table.
      for (int t = 0; t < 7; t++) begin
         int nsl, p;
         nsl = (tv[t].ab_slot >= 0) ? tv[t].ab_slot + 1 : tv[t].n;
         p   = (tv[t].ab_slot >= 0) ? tv[t].ab_slot : tv[t].n - 1;
         run_frame(tv[t].b, tv[t].n, tv[t].ab_slot, tv[t].ab_bits);
         model_frame(tv[t].b, nsl, p);
         exp_w.delete();
         exp_r.delete();
         for (int i = 0; i < tv[t].nw; i++)
            exp_w.push_back({tv[t].wa[i], tv[t].wd[i]});
         for (int i = 0; i < tv[t].nr; i++)
            exp_r.push_back(tv[t].ra[i]);
         for (int k = 0; k < 8; k++)
            exp_m[k] = tv[t].miso[k];
         cmp_frame(tv[t].nm, nsl, tv[t].err);
      end

      // cs_n rises while a write strobe is pending: no write.
      ws = wlog.size();
      rs = rlog.size();
      @(negedge clk);
      bus.spi_cs_n = 1'b0;
      slot(1'b0, 8'h00);
      slot(1'b1, 8'h02);
      slot(1'b1, 8'h50);
      bus.spi_rxdata_valid = 1'b1;
      bus.spi_rxdata       = 8'hE1;
      @(posedge clk);
      #1;
      chk("pending strobe up", bus.reg_wr_en, 1'b1);
      chk("pending strobe addr", bus.reg_addr, 8'h50);
      bus.spi_cs_n = 1'b1;
      #1;
      chk("abort strobe cleared", bus.reg_wr_en, 1'b0);
      chk("abort ptr cleared", bus.reg_addr, 8'h00);
      bus.spi_rxdata_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort no write", wlog.size() - ws, 0);
      apply_writes();

      // Reset in the middle of a read burst.
      @(negedge clk);
      bus.spi_cs_n = 1'b0;
      slot(1'b0, 8'h00);
      slot(1'b1, 8'h03);
      slot(1'b1, 8'h20);
      chk("mid-read tx", bus.spi_txdata, 8'h5A);
      bus.spi_rxdata_valid = 1'b1;
      bus.spi_rxdata       = 8'h00;
      @(posedge clk);
      #1;
      chk("mid-read rd_en", bus.reg_rd_en, 1'b1);
      chk("mid-read ptr", bus.reg_addr, 8'h21);
      rst = 1'b1;
      #1;
      chk("rst tx", bus.spi_txdata, 8'h00);
      chk("rst rd_en", bus.reg_rd_en, 1'b0);
      chk("rst addr", bus.reg_addr, 8'h00);
      chk("rst cmd_err", bus.cmd_err, 1'b0);
      bus.spi_rxdata_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst          = 1'b0;
      bus.spi_cs_n = 1'b1;
      err_m        = 1'b0;
      repeat (2) @(negedge clk);
      run_frame({8'h03,8'h22,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 5, -1, 0);
      model_frame({8'h03,8'h22,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 5, 4);
      cmp_frame("read after reset", 5, err_m);

      // Reset together with cs_n high clears the sticky error.
      run_frame({8'h55,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, -1, 0);
      model_frame({8'h55,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, 2);
      cmp_frame("illegal again", 3, err_m);
      rst = 1'b1;
      #1;
      chk("rst+cs_n cmd_err", bus.cmd_err, 1'b0);
      @(negedge clk);
      rst   = 1'b0;
      err_m = 1'b0;
      repeat (2) @(negedge clk);

      // Random frames against the model.
      for (int r = 0; r < 40; r++) begin
         bytes8_t fb;
         int n, ab, abb, p, nsl, sel;
         sel = int'($urandom_range(0, 9));
         fb[0] = (sel < 4) ? 8'h02 : (sel < 8) ? 8'h03 : 8'($urandom);
         for (int i = 1; i < 8; i++)
            fb[i] = 8'($urandom);
         n   = int'($urandom_range(3, 8));
         ab  = -1;
         abb = 0;
         if ($urandom_range(0, 3) == 0) begin
            ab  = int'($urandom_range(1, n - 1));
            abb = int'($urandom_range(2, 7));
         end
         p   = (ab >= 0) ? ab : n - 1;
         nsl = (ab >= 0) ? ab + 1 : n;
         run_frame(fb, n, ab, abb);
         model_frame(fb, nsl, p);
         cmp_frame("random frame", nsl, err_m);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
